// File: rtl/serial_adder_8.sv
// Bit-serial adder: one full adder (two half adders + OR) reused LSB-first, carry held in a flop.
// Latency: WIDTH cycles from accepted start to valid; result held in DONE until ack.
// Backpressure: start is taken only while ready (IDLE); DONE holds sum/cout until ack is seen.
module serial_adder_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ack,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             c;

    // Full adder built from two half-adder stages and an OR on the carries.
    logic             p;
    logic             g1;
    logic             sum_bit;
    logic             g2;
    logic             c_next;
    logic [WIDTH-1:0] acc_next;

    assign p        = a_sh[0] ^ b_sh[0];
    assign g1       = a_sh[0] & b_sh[0];
    assign sum_bit  = p ^ c;
    assign g2       = p & c;
    assign c_next   = g1 | g2;
    assign acc_next = {sum_bit, acc[WIDTH-1:1]};

    assign ready = (state == IDLE);
    assign valid = (state == DONE);

    // Control: state sequencing and bit counter.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand shifters, carry flop, accumulator and the held result.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            c    <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= cin;
                        acc  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    c    <= c_next;
                    acc  <= acc_next;
                    // The last bit's sum/carry go straight to the outputs on the same edge.
                    if (cnt == LAST) begin
                        sum  <= acc_next;
                        cout <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_8.sv
module tb_serial_adder_8;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ack = 1'b1;
    logic         ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_delay = 0;

    logic [W:0] exp_q[$];
    int         st_q[$];

    serial_adder_8 #(.WIDTH(W)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ack(ack), .ready(ready), .sum(sum), .cout(cout), .valid(valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Consumer: hold ack low for ack_delay cycles of DONE, then accept.
    int done_cnt = 0;
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            ack = (done_cnt >= ack_delay);
            done_cnt = done_cnt + 1;
        end else begin
            done_cnt = 0;
            ack = (ack_delay == 0);
        end
    end

    // Monitor: pops the scoreboard on each new result and checks timing/stability.
    logic       prev_valid = 1'b0;
    int         last_rise = -1;
    int         rise_cyc = 0;
    int         cur_delay = 0;
    logic [W:0] held = '0;
    logic [W:0] exp_v;
    int         st_v;
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            last_rise = -1;
        end else begin
            if (valid && ready) check("ready_and_valid", 1, 0);
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {23'd0, cout, sum}, 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    st_v = st_q.pop_front();
                    check("result", {23'd0, cout, sum}, {23'd0, exp_v});
                    check("latency", cyc - st_v, W);
                end
                if (last_rise >= 0) begin
                    checks = checks + 1;
                    if (cyc - last_rise < W + 2) begin
                        errors = errors + 1;
                        $display("FAIL spacing got %0d want >= %0d", cyc - last_rise, W + 2);
                    end
                end
                last_rise = cyc;
                rise_cyc = cyc;
                cur_delay = ack_delay;
                held = {cout, sum};
            end else if (valid && prev_valid) begin
                check("hold_stable", {23'd0, cout, sum}, {23'd0, held});
            end else if (!valid && prev_valid) begin
                check("valid_width", cyc - rise_cyc, cur_delay + 1);
                check("ready_after_ack", {31'd0, ready}, 1);
            end
            prev_valid = valid;
        end
    end

    // Issue one request once the adder is ready; pushes the expected result.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int n;
        n = 0;
        @(negedge clock);
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (ready !== 1'b1) begin
            check("ready_timeout", {31'd0, ready}, 1);
        end else begin
            a = x; b = y; cin = ci; start = 1'b1;
            exp_q.push_back({1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci});
            st_q.push_back(cyc + 1);
            @(posedge clock);
            #1 start = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ready !== 1'b1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'd0, ready}, 1);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_cout", {31'd0, cout}, 0);

        // Directed adds, ack tied high.
        ack_delay = 0;
        do_add(8'h00, 8'h00, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0);
        do_add(8'hA5, 8'h5A, 1'b1);
        drain();

        // Busy protection: further starts and operand changes during SHIFT are ignored.
        do_add(8'h12, 8'h34, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (k == 3 || k == 8) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0; a = W'($urandom); b = W'($urandom);
            end
        end
        start = 1'b0;
        drain();
        repeat (12) @(negedge clock);
        check("busy_no_extra", exp_q.size(), 0);

        // Ack backpressure.
        ack_delay = 5;
        do_add(8'h3C, 8'hC4, 1'b1);
        drain();
        ack_delay = 0;

        // Reset mid-SHIFT aborts the operation; clears outputs asynchronously.
        do_add(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clock);
        #2 rst_n = 1'b0;
        exp_q.delete();
        st_q.delete();
        #1;
        check("arst_ready", {31'd0, ready}, 1);
        check("arst_valid", {31'd0, valid}, 0);
        check("arst_sum", {24'd0, sum}, 0);
        check("arst_cout", {31'd0, cout}, 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (12) @(negedge clock);
        check("abort_sum", {24'd0, sum}, 0);
        check("abort_cout", {31'd0, cout}, 0);
        do_add(8'h80, 8'h80, 1'b0);
        drain();

        // Randomized operands and consumer delays.
        for (int i = 0; i < 1000; i++) begin
            ack_delay = int'($urandom_range(0, 3));
            do_add(W'($urandom), W'($urandom), 1'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
